// File: rtl/prbs16_checker.sv
// prbs16_checker: receive-side checker for the 16-bit PRBS word stream
// (x^16 + x^13 + x^12 + x^11 + 1, one generator shift per valid word).
// The checker finds the stream in SEARCH by watching for LOCK_CNT
// consecutive correct word-to-word steps. It then runs its own prediction
// in LOCKED and never reseeds from received data.
// Optional feature macro: PRBS_CHK_BITERR_EN adds the bit_err_cnt output.
module prbs16_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_word,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
`ifdef PRBS_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_cnt
`endif
);

  localparam int MR_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MS_W = (LOSS_CNT < 1) ? 1 : $clog2(LOSS_CNT + 1);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[12] ^ x[11] ^ x[10]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            r_state;
  logic [15:0]       r_pred;
  logic [15:0]       r_last;
  logic              r_have_last;
  logic [MR_W-1:0]   r_match_run;
  logic [MS_W-1:0]   r_miss_run;
  logic              r_locked;
  logic              r_err_pulse;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_word_cnt;

  logic              w_chk;
  logic              w_miss;
  logic              w_chain;

  // A valid word is checked only while locked; chain tests the search seed.
  assign w_chk   = in_valid && (r_state == ST_LOCKED);
  assign w_miss  = (in_word != r_pred);
  assign w_chain = r_have_last && (in_word == nxt(r_last));

  // Lock-acquisition / flywheel state machine with registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_pred      <= 16'hFFFF;
      r_last      <= 16'h0000;
      r_have_last <= 1'b0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (in_valid) begin
        if (r_state == ST_SEARCH) begin
          if (in_word == 16'h0000) begin
            // a zero word is a stuck line, never a usable seed
            r_match_run <= '0;
            r_have_last <= 1'b0;
          end else begin
            r_last      <= in_word;
            r_have_last <= 1'b1;
            if (w_chain) begin
              if (r_match_run == MR_W'(LOCK_CNT - 1)) begin
                r_state     <= ST_LOCKED;
                r_locked    <= 1'b1;
                r_pred      <= nxt(in_word);
                r_miss_run  <= '0;
                r_match_run <= '0;
              end else begin
                r_match_run <= r_match_run + 1'b1;
              end
            end else begin
              r_match_run <= '0;
            end
          end
        end else begin
          r_pred <= nxt(r_pred);
          if (w_miss) begin
            r_err_pulse <= 1'b1;
            if (r_miss_run == MS_W'(LOSS_CNT - 1)) begin
              r_state     <= ST_SEARCH;
              r_locked    <= 1'b0;
              r_miss_run  <= '0;
              r_match_run <= '0;
              r_last      <= in_word;
              r_have_last <= (in_word != 16'h0000);
            end else begin
              r_miss_run <= r_miss_run + 1'b1;
            end
          end else begin
            r_miss_run <= '0;
          end
        end
      end
    end
  end

  // Saturating statistics; a clear in the same cycle beats an increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_chk) begin
      r_word_cnt <= sat_inc(r_word_cnt);
      if (w_miss) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

`ifdef PRBS_CHK_BITERR_EN
  localparam int SW = ((CNT_W > 5) ? CNT_W : 5) + 1;

  logic [15:0]      w_diff;
  logic [4:0]       w_pop;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_bit_next;
  logic [CNT_W-1:0] r_bit_err_cnt;

  // Count of differing bits in this word, added with saturation.
  always_comb begin
    w_diff = in_word ^ r_pred;
    w_pop  = '0;
    for (int i = 0; i < 16; i++) begin
      w_pop = w_pop + 5'(w_diff[i]);
    end
    w_sum      = SW'(r_bit_err_cnt) + SW'(w_pop);
    w_bit_next = (|w_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  // Bit-error accumulator, checked words only.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_bit_err_cnt <= '0;
    end else if (w_chk) begin
      r_bit_err_cnt <= w_bit_next;
    end
  end

  assign bit_err_cnt = r_bit_err_cnt;
`endif

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign word_cnt  = r_word_cnt;

endmodule
